// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the display designs: segment bit ordering,
// scanner FSM state encodings and a width helper.
package seven_segment_scanner_pkg;

  // Segment bit positions in the 7-bit segment bus.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Bits needed to count 0..n-1, never less than 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// seven_segment_decoder: combinational hex-to-segment decode.
// Ports:
//   nibble   - 4-bit hex digit
//   segments - active-high segments, bit positions from SEG_A..SEG_G
module seven_segment_decoder
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segments
);

  // pat is written as {g,f,e,d,c,b,a}
  logic [6:0] pat;

  always_comb begin
    case (nibble)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
  end

  always_comb begin
    segments        = '0;
    segments[SEG_A] = pat[0];
    segments[SEG_B] = pat[1];
    segments[SEG_C] = pat[2];
    segments[SEG_D] = pat[3];
    segments[SEG_E] = pat[4];
    segments[SEG_F] = pat[5];
    segments[SEG_G] = pat[6];
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed 7-segment display scanner with
// per-slot anti-ghosting blanking and tear-free, frame-synchronous updates.
// Ports:
//   CLK_IN, RESET_IN         - clock, synchronous active-high reset
//   VALUE_IN, BLANK_MASK_IN  - nibble k / mask bit k belong to digit k
//   VALUE_VLD_IN/RDY_OUT     - update handshake
//   SEGMENT_OUT, DIGIT_OUT   - registered segment and one-hot digit drive
//   FRAME_OUT                - one-cycle pulse at cnt=0, idx=0
//
// state    | meaning
// ST_BLANK | leading BLANK_CYCLES clocks of a slot, all outputs off
// ST_DRIVE | rest of the slot, digit idx driven unless masked
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_PERIOD = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    CLK_IN,
  input  logic                    RESET_IN,
  input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_MASK_IN,
  input  logic                    VALUE_VLD_IN,
  output logic                    VALUE_RDY_OUT,
  output logic [SEG_W-1:0]        SEGMENT_OUT,
  output logic [NUM_DIGITS-1:0]   DIGIT_OUT,
  output logic                    FRAME_OUT
);

  localparam int CW = clog2_min1(DIGIT_PERIOD);
  localparam int IW = clog2_min1(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  scan_state_t            state, nxt_state;
  logic [CW-1:0]          cnt, nxt_cnt;
  logic [IW-1:0]          idx, nxt_idx;
  logic                   run;
  logic [4*NUM_DIGITS-1:0] disp_val, pend_val, nxt_disp_val;
  logic [NUM_DIGITS-1:0]  disp_mask, pend_mask, nxt_disp_mask;
  logic                   pend_vld;
  logic                   accept, take_update;
  logic [3:0]             nxt_nibble;
  logic [SEG_W-1:0]       nxt_seg;

  // Outputs are registered from next-cycle values so they move on the same
  // edge as cnt/idx/state. run holds the counters at 0/0 for the first edge
  // after reset so that cycle becomes the first frame boundary.
  always_comb begin
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_state = state;
    if (run) begin
      if (cnt == CNT_LAST) begin
        nxt_cnt = '0;
        nxt_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end
    case (state)
      ST_BLANK: if (nxt_cnt >= CNT_BLANK) nxt_state = ST_DRIVE;
      ST_DRIVE: if (nxt_cnt < CNT_BLANK)  nxt_state = ST_BLANK;
      default:  nxt_state = ST_BLANK;
    endcase
  end

  // FRAME_OUT marks the current cycle as the boundary; the pending value is
  // committed on the edge leaving it, while the first slot is still blank.
  always_comb begin
    accept        = VALUE_VLD_IN && VALUE_RDY_OUT;
    take_update   = FRAME_OUT && pend_vld;
    nxt_disp_val  = take_update ? pend_val  : disp_val;
    nxt_disp_mask = take_update ? pend_mask : disp_mask;
    nxt_nibble    = nxt_disp_val[nxt_idx*4 +: 4];
  end

  seven_segment_decoder u_decoder (
    .nibble   (nxt_nibble),
    .segments (nxt_seg)
  );

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= '0;
      run           <= 1'b0;
      disp_val      <= '0;
      disp_mask     <= '1;
      pend_val      <= '0;
      pend_mask     <= '0;
      pend_vld      <= 1'b0;
      VALUE_RDY_OUT <= 1'b1;
      SEGMENT_OUT   <= '0;
      DIGIT_OUT     <= '0;
      FRAME_OUT     <= 1'b0;
    end else begin
      run       <= 1'b1;
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      idx       <= nxt_idx;
      disp_val  <= nxt_disp_val;
      disp_mask <= nxt_disp_mask;
      FRAME_OUT <= (nxt_cnt == '0) && (nxt_idx == '0);
      if (nxt_state == ST_DRIVE && !nxt_disp_mask[nxt_idx]) begin
        DIGIT_OUT   <= NUM_DIGITS'(1) << nxt_idx;
        SEGMENT_OUT <= nxt_seg;
      end else begin
        DIGIT_OUT   <= '0;
        SEGMENT_OUT <= '0;
      end
      // accept and take_update are exclusive: take_update needs RDY low.
      if (accept) begin
        pend_val      <= VALUE_IN;
        pend_mask     <= BLANK_MASK_IN;
        pend_vld      <= 1'b1;
        VALUE_RDY_OUT <= 1'b0;
      end else if (take_update) begin
        pend_vld      <= 1'b0;
        VALUE_RDY_OUT <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int DP = 8;
  localparam int BC = 2;
  localparam int FL = ND * DP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [15:0] val = '0;
  logic [3:0]  msk = '0;
  logic        rdy;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        frame;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS   (ND),
    .DIGIT_PERIOD (DP),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK_IN        (clk),
    .RESET_IN      (rst),
    .VALUE_IN      (val),
    .BLANK_MASK_IN (msk),
    .VALUE_VLD_IN  (vld),
    .VALUE_RDY_OUT (rdy),
    .SEGMENT_OUT   (seg),
    .DIGIT_OUT     (dig),
    .FRAME_OUT     (frame)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: absolute cycle t since the first frame boundary.
  int          t = -1;
  logic [15:0] m_dval, m_pval;
  logic [3:0]  m_dmask, m_pmask;
  logic        m_pvld, m_rdy;
  logic [6:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_frame;

  // Lit segment letters for each hex character.
  string segs [16];

  typedef struct {
    logic [15:0] v;
    logic [3:0]  m;
    int          slot;
    logic [6:0]  s;
    logic [3:0]  d;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] r;
    string      s;
    int         b;
    r = '0;
    s = segs[n];
    for (int i = 0; i < s.len(); i++) begin
      b = int'(s.getc(i)) - 97;
      r[b] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic model_edge();
    bit was_boundary, hs;
    int pos, d;
    if (rst) begin
      t = -1; m_dval = '0; m_dmask = 4'hF; m_pvld = 1'b0; m_rdy = 1'b1;
      e_seg = '0; e_dig = '0; e_frame = 1'b0;
    end else begin
      was_boundary = (t >= 0) && (t % FL == 0);
      hs = vld && m_rdy;
      if (was_boundary && m_pvld) begin
        m_dval = m_pval; m_dmask = m_pmask; m_pvld = 1'b0;
      end
      if (hs) begin
        m_pval = val; m_pmask = msk; m_pvld = 1'b1;
      end
      m_rdy = !m_pvld;
      t++;
      pos = t % DP;
      d   = (t / DP) % ND;
      e_frame = (t % FL == 0);
      if (pos < BC || m_dmask[d]) begin
        e_seg = '0; e_dig = '0;
      end else begin
        e_dig = 4'(1 << d);
        e_seg = hexseg(m_dval[d*4 +: 4]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("segment", 32'(seg), 32'(e_seg));
    chk("digit",   32'(dig), 32'(e_dig));
    chk("frame",   32'(frame), 32'(e_frame));
    chk("rdy",     32'(rdy), 32'(m_rdy));
    chk("onehot",  32'($countones(dig) <= 1), 32'd1);
  endtask

  task automatic handshake(input logic [15:0] v, input logic [3:0] m);
    bit r, done;
    int n;
    done = 1'b0; n = 0;
    vld = 1'b1; val = v; msk = m;
    while (!done && n < 200) begin
      r = rdy;
      step();
      n++;
      if (r) done = 1'b1;
    end
    vld = 1'b0;
    chk("hs_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame && n < 100);
    chk("frame_timeout", 32'(frame), 32'd1);
  endtask

  task automatic goto_pos(input int p);
    int n;
    n = 0;
    while ((t < 0 || t % FL != p) && n < 200) begin
      step();
      n++;
    end
    chk("goto_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    segs = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    vecs[0] = '{16'h3210, 4'b0000, 0, 7'b0111111, 4'b0001};
    vecs[1] = '{16'h3210, 4'b0000, 1, 7'b0000110, 4'b0010};
    vecs[2] = '{16'h3210, 4'b0000, 3, 7'b1001111, 4'b1000};
    vecs[3] = '{16'hABCD, 4'b0000, 0, 7'b1011110, 4'b0001};
    vecs[4] = '{16'hABCD, 4'b0000, 3, 7'b1110111, 4'b1000};
    vecs[5] = '{16'h8888, 4'b0100, 2, 7'b0000000, 4'b0000};
    vecs[6] = '{16'h8888, 4'b0100, 1, 7'b1111111, 4'b0010};
    vecs[7] = '{16'hF0E9, 4'b0000, 0, 7'b1101111, 4'b0001};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_seg", 32'(seg), 0);
    chk("rst_dig", 32'(dig), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_rdy", 32'(rdy), 1);

    // Release, no update: frames at 0, 32, 64, display dark
    rst = 1'b0;
    step();
    chk("first_frame", 32'(frame), 1);
    repeat (69) step();

    // Load before the first boundary
    rst = 1'b1;
    step();
    rst = 1'b0;
    handshake(16'h3210, 4'b0000);
    goto_pos(0);
    for (int k = 1; k < 16; k++) begin
      step();
      if (k == 1)  chk("f2_c1_dig", 32'(dig), 0);
      if (k == 2)  begin chk("f2_c2_dig", 32'(dig), 1); chk("f2_c2_seg", 32'(seg), 32'h3F); end
      if (k == 9)  chk("f2_c9_seg", 32'(seg), 0);
      if (k == 10) begin chk("f2_c10_dig", 32'(dig), 2); chk("f2_c10_seg", 32'(seg), 32'h06); end
    end

    // Table-driven loads
    for (int i = 0; i < 8; i++) begin
      handshake(vecs[i].v, vecs[i].m);
      wait_frame();
      goto_pos(vecs[i].slot * DP + 4);
      chk("vec_seg", 32'(seg), 32'(vecs[i].s));
      chk("vec_dig", 32'(dig), 32'(vecs[i].d));
    end

    // Mid-frame update: no tearing, RDY low until after the boundary
    handshake(16'h3210, 4'b0000);
    wait_frame();
    goto_pos(13);
    handshake(16'hABCD, 4'b0000);
    goto_pos(20);
    chk("mid_old_seg", 32'(seg), 32'b1011011);
    chk("mid_rdy_low", 32'(rdy), 0);
    goto_pos(0);
    chk("bnd_rdy_low", 32'(rdy), 0);
    step();
    chk("post_bnd_rdy", 32'(rdy), 1);
    goto_pos(4);
    chk("mid_new_seg", 32'(seg), 32'b1011110);

    // VLD while RDY low is ignored
    handshake(16'h1234, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      vld = (rdy == 1'b0); val = 16'hFFFF; msk = 4'hF;
      step();
    end
    vld = 1'b0;
    wait_frame();
    goto_pos(4);
    chk("ign_d0_seg", 32'(seg), 32'b1100110);
    goto_pos(28);
    chk("ign_d3_seg", 32'(seg), 32'b0000110);

    // Reset at cnt=5, idx=2 with an update pending
    wait_frame();
    handshake(16'h7777, 4'b0000);
    goto_pos(2 * DP + 5);
    chk("pend_rdy_low", 32'(rdy), 0);
    rst = 1'b1;
    step();
    chk("mrst_seg", 32'(seg), 0);
    chk("mrst_dig", 32'(dig), 0);
    chk("mrst_rdy", 32'(rdy), 1);
    rst = 1'b0;
    step();
    chk("mrst_frame", 32'(frame), 1);
    goto_pos(4);
    chk("mrst_dark", 32'(dig), 0);
    repeat (40) step();

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      vld = ($urandom_range(0, 7) == 0);
      val = 16'($urandom);
      msk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    vld = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
